// File: rtl/reg_access_pkg.sv
// -----------------------------------------------------------------------------
// reg_access_pkg
// Shared types and helpers for the multi-host register access front end.
//   arb_state_e     : arbiter FSM states (idle, bank access, host response)
//   PRIORITY_RR     : round-robin arbitration selector
//   PRIORITY_FIXED  : fixed priority, lowest host index wins
//   addr_in_range() : true when a zero-extended address lies below num_regs
// -----------------------------------------------------------------------------
package reg_access_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_e;

    localparam int PRIORITY_RR    = 0;
    localparam int PRIORITY_FIXED = 1;

    // The full host-side address is compared, so any set bit above the bank
    // address width automatically makes the access out of range.
    function automatic logic addr_in_range(input logic [31:0] addr, input int num_regs);
        return addr < 32'(num_regs);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational N-way arbiter, round-robin or fixed priority.
//   req_i     : request vector
//   ptr_i     : index of the last winner (round-robin only)
//   gnt_o     : one-hot grant, all zero when nothing is requested
//   gnt_idx_o : binary index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter
    import reg_access_pkg::*;
#(
    parameter int N    = 2,
    parameter int MODE = PRIORITY_RR,
    localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);

    // Candidates are scanned from the lowest priority to the highest so that
    // the last matching assignment is the winner; this avoids loop breaks.
    always_comb begin
        int j;
        gnt_o     = '0;
        gnt_idx_o = '0;
        j         = 0;
        if (MODE == PRIORITY_FIXED) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    gnt_o     = '0;
                    gnt_o[i]  = 1'b1;
                    gnt_idx_o = IW'(i);
                end
            end
        end else begin
            // Offset 1 from the pointer is the most favoured candidate.
            for (int k = N; k >= 1; k--) begin
                j = (int'(ptr_i) + k) % N;
                if (req_i[j]) begin
                    gnt_o     = '0;
                    gnt_o[j]  = 1'b1;
                    gnt_idx_o = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// reg_access_arbiter
// Multi-host front end for the register bank. Arbitrates read/write requests
// from NUM_HOSTS serial peripherals, performs one bank access per grant,
// range-checks the address and returns data/error to the granted host.
//   clk, rstb        : clock, synchronous active-high reset
//   host_req/wr_rdn  : per-host request level and direction (1 = write)
//   host_addr/wdata  : per-host packed address and write data
//   host_ack         : one-cycle one-hot completion pulse
//   host_err/rdata   : response status and read data, valid with host_ack
//   bank_*           : single register-bank access port
//   grant_id         : index of the host currently or last served
//   contention_cnt   : saturating count of contended arbitration decisions
// -----------------------------------------------------------------------------
module reg_access_arbiter
    import reg_access_pkg::*;
#(
    parameter int NUM_HOSTS     = 2,
    parameter int REG_WIDTH     = 8,
    parameter int NUM_CFG       = 8,
    parameter int NUM_STATUS    = 8,
    parameter int PRIORITY_MODE = 0,
    localparam int ADDR_W       = $clog2(NUM_CFG + NUM_STATUS),
    localparam int GW           = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1
) (
    input  logic                           clk,
    input  logic                           rstb,
    input  logic [NUM_HOSTS-1:0]           host_req,
    input  logic [NUM_HOSTS-1:0]           host_wr_rdn,
    input  logic [NUM_HOSTS*REG_WIDTH-1:0] host_addr,
    input  logic [NUM_HOSTS*REG_WIDTH-1:0] host_wdata,
    output logic [NUM_HOSTS-1:0]           host_ack,
    output logic                           host_err,
    output logic [REG_WIDTH-1:0]           host_rdata,
    output logic                           bank_we,
    output logic                           bank_wr_rdn,
    output logic [ADDR_W-1:0]              bank_addr,
    output logic [REG_WIDTH-1:0]           bank_wdata,
    input  logic [REG_WIDTH-1:0]           bank_rdata,
    output logic [GW-1:0]                  grant_id,
    output logic [7:0]                     contention_cnt
);

    arb_state_e           state_q, state_d;
    logic                 wr_q, wr_d;
    logic [REG_WIDTH-1:0] addr_q, addr_d;
    logic [REG_WIDTH-1:0] wdata_q, wdata_d;
    logic [REG_WIDTH-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        ptr_q, ptr_d;
    logic [7:0]           cnt_q, cnt_d;

    logic [NUM_HOSTS-1:0] arbGnt;
    logic [GW-1:0]        arbIdx;
    logic                 accessErr;

    rr_arbiter #(
        .N    (NUM_HOSTS),
        .MODE (PRIORITY_MODE)
    ) u_arb (
        .req_i     (host_req),
        .ptr_i     (ptr_q),
        .gnt_o     (arbGnt),
        .gnt_idx_o (arbIdx)
    );

    // Out of range anywhere, or a write into the read-only status region.
    assign accessErr = !addr_in_range(32'(addr_q), NUM_CFG + NUM_STATUS)
                     || (wr_q && !addr_in_range(32'(addr_q), NUM_CFG));

    // State register; reset also aborts an in-flight access silently.
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q <= ARB_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            grant_q <= '0;
            ptr_q   <= GW'(NUM_HOSTS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: latch the winner's fields in IDLE, evaluate the
    // access in ACCESS, and spend one cycle acknowledging in RESP.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (|host_req) begin
                    for (int h = 0; h < NUM_HOSTS; h++) begin
                        if (arbGnt[h]) begin
                            wr_d    = host_wr_rdn[h];
                            addr_d  = host_addr[h*REG_WIDTH +: REG_WIDTH];
                            wdata_d = host_wdata[h*REG_WIDTH +: REG_WIDTH];
                        end
                    end
                    grant_d = arbIdx;
                    ptr_d   = arbIdx;
                    if ($countones(host_req) > 1 && cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                err_d   = accessErr;
                rdata_d = accessErr ? '0 : bank_rdata;
                state_d = ARB_RESP;
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Ack decode from the registered grant index.
    always_comb begin
        host_ack = '0;
        for (int h = 0; h < NUM_HOSTS; h++) begin
            host_ack[h] = (state_q == ARB_RESP) && (grant_q == GW'(h));
        end
    end

    assign bank_we        = (state_q == ARB_ACCESS) && wr_q && !accessErr;
    assign bank_wr_rdn    = wr_q;
    assign bank_addr      = addr_q[ADDR_W-1:0];
    assign bank_wdata     = wdata_q;
    assign host_err       = err_q;
    assign host_rdata     = rdata_q;
    assign grant_id       = grant_q;
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_access_arbiter
// Directed bench driving a round-robin and a fixed-priority instance of
// reg_access_arbiter from the same two-host stimulus.
// -----------------------------------------------------------------------------
module tb_reg_access_arbiter;

    logic        clk = 1'b0;
    logic        rstb;
    logic [1:0]  hostReq;
    logic [1:0]  hostWrRdn;
    logic [15:0] hostAddr;
    logic [15:0] hostWdata;
    logic [7:0]  bankRdata;

    logic [1:0]  rrAck, fxAck;
    logic        rrErr, fxErr;
    logic [7:0]  rrRdata, fxRdata;
    logic        rrWe, fxWe;
    logic        rrWrRdn, fxWrRdn;
    logic [3:0]  rrAddr, fxAddr;
    logic [7:0]  rrWdata, fxWdata;
    logic [0:0]  rrGrant, fxGrant;
    logic [7:0]  rrCnt, fxCnt;

    int passCount   = 0;
    int totalChecks = 0;

    always #5 clk = ~clk;

    reg_access_arbiter #(.NUM_HOSTS(2), .REG_WIDTH(8), .NUM_CFG(8), .NUM_STATUS(8),
                         .PRIORITY_MODE(0)) dutRr (
        .clk(clk), .rstb(rstb), .host_req(hostReq), .host_wr_rdn(hostWrRdn),
        .host_addr(hostAddr), .host_wdata(hostWdata), .host_ack(rrAck),
        .host_err(rrErr), .host_rdata(rrRdata), .bank_we(rrWe),
        .bank_wr_rdn(rrWrRdn), .bank_addr(rrAddr), .bank_wdata(rrWdata),
        .bank_rdata(bankRdata), .grant_id(rrGrant), .contention_cnt(rrCnt)
    );

    reg_access_arbiter #(.NUM_HOSTS(2), .REG_WIDTH(8), .NUM_CFG(8), .NUM_STATUS(8),
                         .PRIORITY_MODE(1)) dutFx (
        .clk(clk), .rstb(rstb), .host_req(hostReq), .host_wr_rdn(hostWrRdn),
        .host_addr(hostAddr), .host_wdata(hostWdata), .host_ack(fxAck),
        .host_err(fxErr), .host_rdata(fxRdata), .bank_we(fxWe),
        .bank_wr_rdn(fxWrRdn), .bank_addr(fxAddr), .bank_wdata(fxWdata),
        .bank_rdata(bankRdata), .grant_id(fxGrant), .contention_cnt(fxCnt)
    );

    // Advance one clock and settle just after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input int host, input logic wr, input logic [7:0] addr,
                                 input logic [7:0] wdata);
        hostReq[host]              = 1'b1;
        hostWrRdn[host]            = wr;
        hostAddr[host*8 +: 8]      = addr;
        hostWdata[host*8 +: 8]     = wdata;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " rr ack"},   32'(rrAck),   0);
        checkOutput({tag, " rr err"},   32'(rrErr),   0);
        checkOutput({tag, " rr rdata"}, 32'(rrRdata), 0);
        checkOutput({tag, " rr we"},    32'(rrWe),    0);
        checkOutput({tag, " rr dir"},   32'(rrWrRdn), 0);
        checkOutput({tag, " rr addr"},  32'(rrAddr),  0);
        checkOutput({tag, " rr wdata"}, 32'(rrWdata), 0);
        checkOutput({tag, " rr grant"}, 32'(rrGrant), 0);
        checkOutput({tag, " rr cnt"},   32'(rrCnt),   0);
        checkOutput({tag, " fx ack"},   32'(fxAck),   0);
        checkOutput({tag, " fx we"},    32'(fxWe),    0);
        checkOutput({tag, " fx cnt"},   32'(fxCnt),   0);
    endtask

    // One uncontended access from a single host, checked on both instances.
    task automatic runAccess(input string tag, input int host, input logic wr,
                             input logic [7:0] addr, input logic [7:0] wdata,
                             input logic [7:0] rd, input logic expWe,
                             input logic expErr, input logic [7:0] expRdata);
        applyStimulus(host, wr, addr, wdata);
        bankRdata = rd;
        tick();
        checkOutput({tag, " rr we"}, 32'(rrWe), 32'(expWe));
        checkOutput({tag, " fx we"}, 32'(fxWe), 32'(expWe));
        if (!expErr) begin
            checkOutput({tag, " rr addr"}, 32'(rrAddr), 32'(addr[3:0]));
            checkOutput({tag, " rr dir"},  32'(rrWrRdn), 32'(wr));
            if (wr) checkOutput({tag, " rr wdata"}, 32'(rrWdata), 32'(wdata));
        end
        tick();
        checkOutput({tag, " rr ack"},   32'(rrAck),   32'(2'b01 << host));
        checkOutput({tag, " fx ack"},   32'(fxAck),   32'(2'b01 << host));
        checkOutput({tag, " rr err"},   32'(rrErr),   32'(expErr));
        checkOutput({tag, " fx err"},   32'(fxErr),   32'(expErr));
        checkOutput({tag, " rr rdata"}, 32'(rrRdata), 32'(expRdata));
        checkOutput({tag, " rr grant"}, 32'(rrGrant), 32'(host));
        checkOutput({tag, " rr we idle"}, 32'(rrWe), 0);
        hostReq = '0;
        tick();
    endtask

    initial begin
        logic [1:0] expRrAck;
        int         expCnt;
        rstb      = 1'b1;
        hostReq   = '0;
        hostWrRdn = '0;
        hostAddr  = '0;
        hostWdata = '0;
        bankRdata = '0;
        tick();
        tick();
        checkAllZero("reset");
        rstb = 1'b0;
        tick();

        runAccess("wr h0 a03",  0, 1'b1, 8'h03, 8'hA5, 8'h00, 1'b1, 1'b0, 8'h00);
        runAccess("rd h1 a09",  1, 1'b0, 8'h09, 8'h00, 8'h5C, 1'b0, 1'b0, 8'h5C);

        // Both hosts requesting continuously: RR alternates, fixed stays on 0.
        hostAddr = {8'h01, 8'h02};
        hostWrRdn = 2'b00;
        hostReq  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            tick();
            expRrAck = (i % 2 == 0) ? 2'b01 : 2'b10;
            checkOutput($sformatf("contend%0d rr ack", i), 32'(rrAck), 32'(expRrAck));
            checkOutput($sformatf("contend%0d fx ack", i), 32'(fxAck), 32'(2'b01));
            tick();
        end
        hostReq = '0;
        checkOutput("contend rr cnt", 32'(rrCnt), 4);
        checkOutput("contend fx cnt", 32'(fxCnt), 4);
        tick();

        runAccess("wr status a0A", 0, 1'b1, 8'h0A, 8'h11, 8'h77, 1'b0, 1'b1, 8'h00);
        runAccess("rd oor a40",    1, 1'b0, 8'h40, 8'h00, 8'h77, 1'b0, 1'b1, 8'h00);
        runAccess("rd oor a10",    0, 1'b0, 8'h10, 8'h00, 8'h66, 1'b0, 1'b1, 8'h00);
        runAccess("rd last a0F",   1, 1'b0, 8'h0F, 8'h00, 8'h3E, 1'b0, 1'b0, 8'h3E);
        runAccess("wr cfg a07",    1, 1'b1, 8'h07, 8'hC3, 8'h21, 1'b1, 1'b0, 8'h21);

        // Reset during the access phase of a host 0 write.
        applyStimulus(0, 1'b1, 8'h02, 8'h33);
        tick();
        checkOutput("abort pre we", 32'(rrWe), 1);
        rstb = 1'b1;
        tick();
        checkAllZero("abort");
        rstb     = 1'b0;
        hostAddr = {8'h05, 8'h04};
        hostWrRdn = 2'b00;
        hostReq  = 2'b11;

        // Long contention run: RR restarts at host 0 and the counter saturates.
        expCnt = 0;
        for (int i = 0; i < 301; i++) begin
            tick();
            tick();
            expCnt   = (expCnt < 255) ? expCnt + 1 : 255;
            expRrAck = (i % 2 == 0) ? 2'b01 : 2'b10;
            checkOutput($sformatf("sat%0d rr ack", i), 32'(rrAck), 32'(expRrAck));
            checkOutput($sformatf("sat%0d rr cnt", i), 32'(rrCnt), 32'(expCnt));
            checkOutput($sformatf("sat%0d fx cnt", i), 32'(fxCnt), 32'(expCnt));
            tick();
        end
        hostReq = '0;
        tick();

        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end

endmodule
